alu_divider: RTL and testbench

Iterative radix-2 divider for the RV64M divide and remainder instructions: DIV, DIVU, REM, REMU. It sits in the execute stage beside the combinational ALU. It takes the same A/B operands and Func3 once ALU_Control has decoded an M-extension divide (Func7 = 7'b0000001, Func3[2] = 1). It returns the result to the same writeback mux through a start/busy/done handshake, so divides no longer need a single-cycle combinational `/`.

---
 rtl/alu_divider.sv | 137 +++++++++++++
 tb/tb_alu_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
// Start/Busy/Done handshake; zero-divisor and signed-overflow cases finish in one cycle.
module alu_divider #(
  parameter int XLEN = 64
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [2:0]      Func3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic            DivByZero
);

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_rem_q, is_rem_d;
  logic            quot_neg_q, quot_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            dbz_q, dbz_d;

  logic            req_signed, req_rem;
  logic [XLEN:0]   rem_shift, rem_sub;
  logic            sub_ok;
  logic [XLEN-1:0] fin_quo, fin_rem;

  // Func3[2] = 0 decodes as DIVU: neither signed nor remainder.
  assign req_signed = Func3[2] & ~Func3[0];
  assign req_rem    = Func3[2] &  Func3[1];

  // The shifted partial remainder is XLEN+1 bits so the compare never overflows;
  // after a restoring step it always fits back into XLEN bits.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_sub   = rem_shift - {1'b0, dvs_q};
  assign sub_ok    = rem_shift >= {1'b0, dvs_q};
  assign fin_quo   = {quo_q[XLEN-2:0], sub_ok};
  assign fin_rem   = sub_ok ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];

  // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    is_rem_d   = is_rem_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          is_rem_d = req_rem;
          if (B == '0) begin
            state_d  = DONE;
            result_d = req_rem ? A : '1;
            dbz_d    = 1'b1;
          end else if (req_signed && A == MIN_NEG && B == '1) begin
            state_d  = DONE;
            result_d = req_rem ? '0 : A;
            dbz_d    = 1'b0;
          end else begin
            state_d    = CALC;
            quo_d      = (req_signed && A[XLEN-1]) ? -A : A;
            dvs_d      = (req_signed && B[XLEN-1]) ? -B : B;
            rem_d      = '0;
            cnt_d      = CNT_LOAD;
            quot_neg_d = req_signed & (A[XLEN-1] ^ B[XLEN-1]);
            rem_neg_d  = req_signed & A[XLEN-1];
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = fin_rem;
        quo_d = fin_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          dbz_d    = 1'b0;
          result_d = is_rem_q ? (rem_neg_q  ? -fin_rem : fin_rem)
                              : (quot_neg_q ? -fin_quo : fin_quo);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      is_rem_q   <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      is_rem_q   <= is_rem_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
    end
  end

  assign Busy      = (state_q == CALC);
  assign Done      = (state_q == DONE);
  assign Result    = result_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider (XLEN=64): directed vector table,
// multi-cycle corner sequences, and a golden-model random sweep.
module tb_alu_divider;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        Clk, Reset, Start;
  logic [2:0]  Func3;
  logic [63:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [63:0] Result;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_divider #(.XLEN(64)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Func3(Func3), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Result(Result), .DivByZero(DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(string n, logic [2:0] f, logic [63:0] a, logic [63:0] b,
                              logic [63:0] r, logic dbz, int lat);
    vec_t v;
    v.name = n; v.f = f; v.a = a; v.b = b; v.r = r; v.dbz = dbz; v.lat = lat;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Operands are scrambled after the Start cycle: the DUT must have latched them.
  task automatic issue(logic [2:0] f, logic [63:0] a, logic [63:0] b);
    @(negedge Clk);
    Func3 = f; A = a; B = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; A = ~a; B = ~b; Func3 = ~f;
  endtask

  // Called one half-cycle after the Start edge; lat counts that point as 1.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (!Done && lat < 200) begin
      if (Busy) busy_n++;
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic run_op(string name, logic [2:0] f, logic [63:0] a, logic [63:0] b,
                        logic [63:0] r, logic dbz, int lat_exp);
    int lat, busy_n;
    issue(f, a, b);
    wait_done(lat, busy_n);
    check({name, "_lat"}, 64'(lat), 64'(lat_exp));
    check({name, "_res"}, Result, r);
    check({name, "_dbz"}, {63'd0, DivByZero}, {63'd0, dbz});
    check({name, "_busycnt"}, 64'(busy_n), (lat_exp == 65) ? 64'd64 : 64'd0);
    check({name, "_busy_at_done"}, {63'd0, Busy}, 64'd0);
    @(negedge Clk);
    check({name, "_done_pulse"}, {63'd0, Done}, 64'd0);
  endtask

  function automatic void golden(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic dbz, output int lat);
    logic sgn, rm;
    sgn = f[2] & ~f[0];
    rm  = f[2] & f[1];
    dbz = 1'b0;
    lat = 65;
    if (b == 64'd0) begin
      dbz = 1'b1; lat = 1; r = rm ? a : ONES;
    end else if (sgn && a == MINV && b == ONES) begin
      lat = 1; r = rm ? 64'd0 : a;
    end else if (sgn) begin
      r = rm ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    end else begin
      r = rm ? a % b : a / b;
    end
  endfunction

  initial begin
    int lat, busy_n, done_seen;
    logic [63:0] ra, rb, rr;
    logic rdbz;
    int rlat;

    vecs[0]  = mk("divu_40_5",     3'b101, 64'd40,   64'd5,             64'd8,   1'b0, 65);
    vecs[1]  = mk("div_m7_2",      3'b100, -64'd7,   64'd2,             -64'd3,  1'b0, 65);
    vecs[2]  = mk("rem_m7_2",      3'b110, -64'd7,   64'd2,             ONES,    1'b0, 65);
    vecs[3]  = mk("remu_7_m2",     3'b111, 64'd7,    ONES - 64'd1,      64'd7,   1'b0, 65);
    vecs[4]  = mk("div_by0",       3'b100, 64'd123,  64'd0,             ONES,    1'b1, 1);
    vecs[5]  = mk("remu_by0",      3'b111, 64'd123,  64'd0,             64'd123, 1'b1, 1);
    vecs[6]  = mk("div_ovf",       3'b100, MINV,     ONES,              MINV,    1'b0, 1);
    vecs[7]  = mk("rem_ovf",       3'b110, MINV,     ONES,              64'd0,   1'b0, 1);
    vecs[8]  = mk("divu_min_ones", 3'b101, MINV,     ONES,              64'd0,   1'b0, 65);
    vecs[9]  = mk("rem_7_m2",      3'b110, 64'd7,    -64'd2,            64'd1,   1'b0, 65);
    vecs[10] = mk("div_7_m2",      3'b100, 64'd7,    -64'd2,            -64'd3,  1'b0, 65);
    vecs[11] = mk("f000_as_divu",  3'b000, 64'd100,  64'd7,             64'd14,  1'b0, 65);
    vecs[12] = mk("divu_ones_1",   3'b101, ONES,     64'd1,             ONES,    1'b0, 65);
    vecs[13] = mk("div_min_2",     3'b100, MINV,     64'd2,             64'hC000_0000_0000_0000, 1'b0, 65);
    vecs[14] = mk("remu_100_7",    3'b111, 64'd100,  64'd7,             64'd2,   1'b0, 65);
    vecs[15] = mk("rem_m100_7",    3'b110, -64'd100, 64'd7,             -64'd2,  1'b0, 65);

    Reset = 1'b1; Start = 1'b0; Func3 = 3'b0; A = '0; B = '0;
    repeat (3) @(negedge Clk);
    check("rst_busy",   {63'd0, Busy},      64'd0);
    check("rst_done",   {63'd0, Done},      64'd0);
    check("rst_result", Result,             64'd0);
    check("rst_dbz",    {63'd0, DivByZero}, 64'd0);
    Reset = 1'b0;

    for (int i = 0; i < 16; i++)
      run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].dbz, vecs[i].lat);

    // Start re-pulsed mid-CALC with other operands must be ignored.
    issue(3'b101, 64'd1000, 64'd7);
    lat = 1;
    while (!Done && lat < 200) begin
      Start = (lat == 10);
      if (lat == 10) begin Func3 = 3'b100; A = 64'd5; B = 64'd1; end
      @(negedge Clk);
      lat++;
    end
    Start = 1'b0;
    check("midstart_lat", 64'(lat), 64'd65);
    check("midstart_res", Result, 64'd142);
    @(negedge Clk);
    check("midstart_no_queue", {62'd0, Busy, Done}, 64'd0);

    // Reset at cycle 30 of CALC: outputs clear, in-flight op never completes.
    issue(3'b101, 64'd999, 64'd3);
    repeat (29) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("midrst_busy",   {63'd0, Busy},      64'd0);
    check("midrst_done",   {63'd0, Done},      64'd0);
    check("midrst_result", Result,             64'd0);
    check("midrst_dbz",    {63'd0, DivByZero}, 64'd0);
    done_seen = 0;
    repeat (80) begin
      @(negedge Clk);
      if (Done) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);

    // Back-to-back: Start held through a special-case Done issues a normal divide.
    @(negedge Clk);
    Func3 = 3'b100; A = 64'd123; B = 64'd0; Start = 1'b1;
    @(negedge Clk);
    check("b2b_first_done", {63'd0, Done}, 64'd1);
    check("b2b_first_res",  Result, ONES);
    check("b2b_first_dbz",  {63'd0, DivByZero}, 64'd1);
    Func3 = 3'b101; A = 64'd40; B = 64'd5;
    @(negedge Clk);
    Start = 1'b0;
    check("b2b_second_busy", {63'd0, Busy}, 64'd1);
    wait_done(lat, busy_n);
    check("b2b_second_lat", 64'(lat), 64'd65);
    check("b2b_second_res", Result, 64'd8);
    check("b2b_second_dbz", {63'd0, DivByZero}, 64'd0);
    @(negedge Clk);

    // Random sweep against the language's own / and %.
    for (int op = 4; op < 8; op++) begin
      for (int k = 0; k < 40; k++) begin
        ra = {$urandom, $urandom} >> $urandom_range(0, 40);
        rb = {$urandom, $urandom} >> $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) ra = -ra;
        if ($urandom_range(0, 3) == 0) rb = -rb;
        if ($urandom_range(0, 15) == 0) rb = 64'd0;
        if ($urandom_range(0, 15) == 0) begin ra = MINV; rb = ONES; end
        golden(3'(op), ra, rb, rr, rdbz, rlat);
        run_op($sformatf("rand_f%0d_%0d", op, k), 3'(op), ra, rb, rr, rdbz, rlat);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
